// File: rtl/bp_be_wb_arbiter.sv
// rtl/bp_be_wb_arbiter.sv - writeback arbiter merging the pipe result with buffered long-latency results
module bp_be_wb_arbiter #(
    parameter int data_width_p     = 64,
    parameter int reg_addr_width_p = 5,
    parameter int fifo_els_p       = 4,
    parameter int starve_limit_p   = 8,
    parameter int zero_x0_p        = 1
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               pipe_v_i,
    input  logic [reg_addr_width_p-1:0]        pipe_addr_i,
    input  logic [data_width_p-1:0]            pipe_data_i,
    input  logic                               long_v_i,
    input  logic [reg_addr_width_p-1:0]        long_addr_i,
    input  logic [data_width_p-1:0]            long_data_i,
    output logic                               long_ready_and_o,
    output logic                               rd_w_v_o,
    output logic [reg_addr_width_p-1:0]        rd_addr_o,
    output logic [data_width_p-1:0]            rd_data_o,
    output logic [$clog2(fifo_els_p+1)-1:0]    fifo_count_o,
    output logic                               starve_o
);

    localparam int cnt_w_lp    = $clog2(fifo_els_p + 1);
    localparam int ptr_w_lp    = $clog2(fifo_els_p);
    localparam int starve_w_lp = $clog2(starve_limit_p + 1);

    logic [cnt_w_lp-1:0]         count_r;
    logic [ptr_w_lp-1:0]         rd_ptr_r;
    logic [ptr_w_lp-1:0]         wr_ptr_r;
    logic [starve_w_lp-1:0]      starve_cnt_r;
    logic [starve_w_lp-1:0]      starve_cnt_n;
    logic [reg_addr_width_p-1:0] mem_addr [fifo_els_p];
    logic [data_width_p-1:0]     mem_data [fifo_els_p];

    logic                        fifo_nonempty;
    logic                        long_xfer;
    logic                        sel_v;
    logic                        deq;
    logic                        byp;
    logic                        enq;
    logic                        drop_x0;
    logic [reg_addr_width_p-1:0] sel_addr;
    logic [data_width_p-1:0]     sel_data;

    // Ready is a pure function of the registered occupancy, never of this cycle's inputs.
    assign long_ready_and_o = (count_r < cnt_w_lp'(fifo_els_p));
    assign fifo_count_o     = count_r;
    assign fifo_nonempty    = (count_r != '0);
    assign long_xfer        = long_v_i & long_ready_and_o;

    always_comb begin
        sel_v    = 1'b0;
        deq      = 1'b0;
        byp      = 1'b0;
        sel_addr = pipe_addr_i;
        sel_data = pipe_data_i;
        if (pipe_v_i) begin
            sel_v = 1'b1;
        end else if (fifo_nonempty) begin
            sel_v    = 1'b1;
            deq      = 1'b1;
            sel_addr = mem_addr[rd_ptr_r];
            sel_data = mem_data[rd_ptr_r];
        end else if (long_xfer) begin
            sel_v    = 1'b1;
            byp      = 1'b1;
            sel_addr = long_addr_i;
            sel_data = long_data_i;
        end
    end

    assign enq     = long_xfer & ~byp;
    assign drop_x0 = (zero_x0_p != 0) && (sel_addr == '0);

    // Starvation only accrues while the head sits behind a busy pipe.
    always_comb begin
        starve_cnt_n = starve_cnt_r;
        if (deq || !fifo_nonempty) begin
            starve_cnt_n = '0;
        end else if (pipe_v_i && (starve_cnt_r != starve_w_lp'(starve_limit_p))) begin
            starve_cnt_n = starve_cnt_r + starve_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_addr[wr_ptr_r] <= long_addr_i;
            mem_data[wr_ptr_r] <= long_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r      <= '0;
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            starve_cnt_r <= '0;
            starve_o     <= 1'b0;
            rd_w_v_o     <= 1'b0;
            rd_addr_o    <= '0;
            rd_data_o    <= '0;
        end else begin
            if (enq) begin
                wr_ptr_r <= wr_ptr_r + ptr_w_lp'(1);
            end
            if (deq) begin
                rd_ptr_r <= rd_ptr_r + ptr_w_lp'(1);
            end
            if (enq && !deq) begin
                count_r <= count_r + cnt_w_lp'(1);
            end else if (deq && !enq) begin
                count_r <= count_r - cnt_w_lp'(1);
            end
            starve_cnt_r <= starve_cnt_n;
            starve_o     <= (starve_cnt_n == starve_w_lp'(starve_limit_p));
            rd_w_v_o     <= sel_v & ~drop_x0;
            if (sel_v) begin
                rd_addr_o <= sel_addr;
                rd_data_o <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_bp_be_wb_arbiter.sv
// tb/tb_bp_be_wb_arbiter.sv - self-checking bench for bp_be_wb_arbiter
module tb_bp_be_wb_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int N  = 4;
    localparam int SL = 8;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          pipe_v_i = 1'b0;
    logic [AW-1:0] pipe_addr_i = '0;
    logic [DW-1:0] pipe_data_i = '0;
    logic          long_v_i = 1'b0;
    logic [AW-1:0] long_addr_i = '0;
    logic [DW-1:0] long_data_i = '0;
    logic          long_ready_and_o;
    logic          rd_w_v_o;
    logic [AW-1:0] rd_addr_o;
    logic [DW-1:0] rd_data_o;
    logic [CW-1:0] fifo_count_o;
    logic          starve_o;

    bp_be_wb_arbiter #(
        .data_width_p(DW), .reg_addr_width_p(AW), .fifo_els_p(N),
        .starve_limit_p(SL), .zero_x0_p(1)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .pipe_v_i(pipe_v_i), .pipe_addr_i(pipe_addr_i), .pipe_data_i(pipe_data_i),
        .long_v_i(long_v_i), .long_addr_i(long_addr_i), .long_data_i(long_data_i),
        .long_ready_and_o(long_ready_and_o),
        .rd_w_v_o(rd_w_v_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
        .fifo_count_o(fifo_count_o), .starve_o(starve_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of pending long results plus the last write it predicts.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    ent_t          m_sel;
    bit            m_have;
    bit            m_byp;
    bit            m_lx;
    int            m_pre;
    bit            m_v = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    int            m_sc = 0;
    bit            m_starve = 0;

    always @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            q.delete();
            m_v = 0; m_addr = '0; m_data = '0; m_sc = 0; m_starve = 0;
        end else begin
            m_pre  = q.size();
            m_lx   = long_v_i && (m_pre < N);
            m_have = 0;
            m_byp  = 0;
            if (pipe_v_i) begin
                m_sel = '{a: pipe_addr_i, d: pipe_data_i}; m_have = 1;
            end else if (m_pre > 0) begin
                m_sel = q.pop_front(); m_have = 1;
            end else if (m_lx) begin
                m_sel = '{a: long_addr_i, d: long_data_i}; m_have = 1; m_byp = 1;
            end
            if (m_lx && !m_byp) q.push_back('{a: long_addr_i, d: long_data_i});
            if (m_pre == 0 || !pipe_v_i) m_sc = 0;
            else if (m_sc < SL) m_sc++;
            m_starve = (m_sc == SL);
            m_v = m_have && (m_sel.a != '0);
            if (m_have) begin
                m_addr = m_sel.a;
                m_data = m_sel.d;
            end
        end
    end

    always @(negedge clk) begin
        chk("rd_w_v", 64'(rd_w_v_o), 64'(m_v));
        chk("rd_addr", 64'(rd_addr_o), 64'(m_addr));
        chk("rd_data", rd_data_o, m_data);
        chk("count", 64'(fifo_count_o), 64'(q.size()));
        chk("ready", 64'(long_ready_and_o), 64'(q.size() < N));
        chk("starve", 64'(starve_o), 64'(m_starve));
    end

    task automatic cyc(input bit pv, input int pa, input logic [63:0] pd,
                       input bit lv, input int la, input logic [63:0] ld);
        pipe_v_i = pv; pipe_addr_i = AW'(pa); pipe_data_i = pd;
        long_v_i = lv; long_addr_i = AW'(la); long_data_i = ld;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_v", 64'(rd_w_v_o), 0);
        chk("rst_count", 64'(fifo_count_o), 0);
        chk("rst_ready", 64'(long_ready_and_o), 1);
        reset_n_i = 1'b1;
        idle();

        cyc(0, 0, 0, 1, 3, 'hAA);
        chk("byp_v", 64'(rd_w_v_o), 1);
        chk("byp_addr", 64'(rd_addr_o), 3);
        chk("byp_data", rd_data_o, 'hAA);
        chk("byp_count", 64'(fifo_count_o), 0);

        cyc(1, 5, 'h11, 1, 6, 'h22);
        chk("pri1_addr", 64'(rd_addr_o), 5);
        chk("pri1_data", rd_data_o, 'h11);
        chk("pri1_count", 64'(fifo_count_o), 1);
        idle();
        chk("pri2_v", 64'(rd_w_v_o), 1);
        chk("pri2_addr", 64'(rd_addr_o), 6);
        chk("pri2_data", rd_data_o, 'h22);
        chk("pri2_count", 64'(fifo_count_o), 0);

        for (int i = 0; i < 4; i++) cyc(1, 7, 'h70 + i, 1, i + 1, 'h100 + i);
        chk("full_count", 64'(fifo_count_o), 4);
        chk("full_ready", 64'(long_ready_and_o), 0);
        cyc(1, 7, 'h77, 1, 9, 'h999);
        chk("full5_count", 64'(fifo_count_o), 4);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("full_wr_v", 64'(rd_w_v_o), 1);
            chk("full_wr_addr", 64'(rd_addr_o), 64'(i + 1));
            chk("full_wr_data", rd_data_o, 64'('h100 + i));
        end
        chk("full_drained", 64'(fifo_count_o), 0);

        cyc(1, 8, 'h80, 1, 10, 'hA0);
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 8, 'h80 + i, 0, 0, 0);
            if (i == 7) chk("starve_pre", 64'(starve_o), 0);
        end
        chk("starve_on", 64'(starve_o), 1);
        chk("starve_pipe_wins", rd_data_o, 'h88);
        idle();
        chk("starve_deq_addr", 64'(rd_addr_o), 10);
        chk("starve_deq_data", rd_data_o, 'hA0);
        chk("starve_off", 64'(starve_o), 0);

        cyc(0, 0, 0, 1, 0, 'h55);
        chk("x0_byp_v", 64'(rd_w_v_o), 0);
        chk("x0_byp_count", 64'(fifo_count_o), 0);
        cyc(1, 4, 'h44, 1, 0, 'h66);
        idle();
        chk("x0_fifo_v", 64'(rd_w_v_o), 0);
        chk("x0_fifo_count", 64'(fifo_count_o), 0);

        for (int i = 0; i < 40; i++)
            cyc((i % 3) != 2, (i % 31) + 1, 64'(i * 7), (i % 4) != 3, i % 5, 64'('h1000 + i));
        repeat (6) idle();

        for (int i = 0; i < 3; i++) cyc(1, 1, 'h1, 1, 20 + i, 'h200 + i);
        chk("rst_mid_count3", 64'(fifo_count_o), 3);
        long_v_i = 1'b0;
        @(posedge clk);
        #2 reset_n_i = 1'b0;
        #1;
        chk("rst_mid_v", 64'(rd_w_v_o), 0);
        chk("rst_mid_addr", 64'(rd_addr_o), 0);
        chk("rst_mid_data", rd_data_o, 0);
        chk("rst_mid_count", 64'(fifo_count_o), 0);
        chk("rst_mid_starve", 64'(starve_o), 0);
        @(negedge clk);
        pipe_v_i = 1'b0;
        reset_n_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("rst_after_v", 64'(rd_w_v_o), 0);
            chk("rst_after_ready", 64'(long_ready_and_o), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
